// File: rtl/frame_gen.sv
// Framing stage: turns a length request into a head/valid/tail beat stream with
// a programmable idle gap after each frame; downstream stall freezes the stream.
module frame_gen #(
    parameter int LEN_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             req_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic             stall_i,
    output logic             ack_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             head_o,
    output logic             tail_o,
    output logic             valid_o,
    output logic [LEN_W-1:0] beat_cnt_o
);

    localparam int GAP_W = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic             ack_q;
    logic             err_q;
    logic             busy_q;
    logic             head_q;
    logic             tail_q;
    logic             valid_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            gap_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        if (req_len_i != '0) begin
                            state_q    <= S_BEAT;
                            len_q      <= req_len_i;
                            beat_cnt_q <= '0;
                            head_q     <= 1'b1;
                            tail_q     <= (req_len_i == LEN_ONE);
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            ack_q      <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_BEAT: begin
                    // A stalled beat keeps every beat output exactly as it is.
                    if (!stall_i) begin
                        if (!tail_q) begin
                            beat_cnt_q <= beat_cnt_q + LEN_ONE;
                            head_q     <= 1'b0;
                            tail_q     <= ((beat_cnt_q + LEN_ONE) == (len_q - LEN_ONE));
                        end else begin
                            valid_q    <= 1'b0;
                            head_q     <= 1'b0;
                            tail_q     <= 1'b0;
                            beat_cnt_q <= '0;
                            if (GAP == 0) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_GAP;
                                gap_q   <= GAP_LOAD;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    head_q  <= 1'b0;
                    tail_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;
    assign head_o     = head_q;
    assign tail_o     = tail_q;
    assign valid_o    = valid_q;
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_frame_gen.sv
// Bench for frame_gen: expected beats are queued per request and popped as the
// stream transfers them; gap length, ack/err pulses and reset are checked too.
module tb_frame_gen;

    localparam int LEN_W = 8;
    localparam int GAP   = 2;

    logic             clock_i;
    logic             reset_ni;
    logic             req_i;
    logic [LEN_W-1:0] req_len_i;
    logic             stall_i;
    logic             ack_o;
    logic             err_o;
    logic             busy_o;
    logic             head_o;
    logic             tail_o;
    logic             valid_o;
    logic [LEN_W-1:0] beat_cnt_o;

    typedef struct {
        logic             head;
        logic             tail;
        logic [LEN_W-1:0] cnt;
    } beat_t;

    beat_t q[$];
    int    nchecks = 0;
    int    nerr    = 0;

    frame_gen #(.LEN_W(LEN_W), .GAP(GAP)) dut (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .req_i      (req_i),
        .req_len_i  (req_len_i),
        .stall_i    (stall_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .head_o     (head_o),
        .tail_o     (tail_o),
        .valid_o    (valid_o),
        .beat_cnt_o (beat_cnt_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic push_frame(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.head = (i == 0);
            b.tail = (i == len - 1);
            b.cnt  = LEN_W'(i);
            q.push_back(b);
        end
    endtask

    // Called at the negedge right after the request edge; runs until IDLE.
    task automatic drain(input int stall_at, input int stall_n, input bit gap_req,
                         output int vcyc, output int gcyc, output int acks);
        int    budget;
        int    st;
        beat_t exp_b;
        budget = 0;
        st     = 0;
        vcyc   = 0;
        gcyc   = 0;
        acks   = 0;
        while ((q.size() > 0 || busy_o) && budget < 400) begin
            budget++;
            if (ack_o) acks++;
            if (valid_o) begin
                vcyc++;
                stall_i = (int'(beat_cnt_o) == stall_at) && (st < stall_n);
                if (stall_i) st++;
                nchecks++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL extra_beat: got beat_cnt=%0d, required no beat", beat_cnt_o);
                end else begin
                    exp_b = q[0];
                    if (head_o !== exp_b.head || tail_o !== exp_b.tail || beat_cnt_o !== exp_b.cnt) begin
                        nerr++;
                        $display("FAIL beat: got head=%b tail=%b cnt=%0d, required head=%b tail=%b cnt=%0d",
                                 head_o, tail_o, beat_cnt_o, exp_b.head, exp_b.tail, exp_b.cnt);
                    end
                    if (!stall_i) void'(q.pop_front());
                end
            end else begin
                stall_i = (budget % 2 == 0);
                nchecks++;
                if (head_o !== 1'b0 || tail_o !== 1'b0 || beat_cnt_o !== '0) begin
                    nerr++;
                    $display("FAIL idle_outputs: got head=%b tail=%b cnt=%0d, required 0 0 0",
                             head_o, tail_o, beat_cnt_o);
                end
                if (busy_o) begin
                    gcyc++;
                    if (gap_req) begin
                        nchecks++;
                        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
                            nerr++;
                            $display("FAIL gap_req: got ack=%b err=%b, required 0 0", ack_o, err_o);
                        end
                        req_i     = 1'b1;
                        req_len_i = '0;
                    end
                end
            end
            @(negedge clock_i);
        end
        stall_i = 1'b0;
        if (gap_req) req_i = 1'b0;
        nchecks++;
        if (budget >= 400) begin
            nerr++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0", q.size());
        end
    endtask

    task automatic request(input int len);
        @(negedge clock_i);
        req_i     = 1'b1;
        req_len_i = LEN_W'(len);
        @(negedge clock_i);
        req_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_ni  = 1'b0;
        req_i     = 1'b0;
        req_len_i = '0;
        stall_i   = 1'b0;
        repeat (3) @(negedge clock_i);
        nchecks++;
        if ({ack_o, err_o, busy_o, head_o, tail_o, valid_o} !== 6'b0 || beat_cnt_o !== '0) begin
            nerr++;
            $display("FAIL reset_state: got ack/err/busy/head/tail/valid=%b cnt=%0d, required all 0",
                     {ack_o, err_o, busy_o, head_o, tail_o, valid_o}, beat_cnt_o);
        end
        reset_ni = 1'b1;
        @(negedge clock_i);
        nchecks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: got busy=%b valid=%b, required 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_basic_frame();
        int v, g, a;
        push_frame(4);
        request(4);
        drain(-1, 0, 1'b0, v, g, a);
        nchecks++;
        if (v != 4 || g != GAP || a != 1) begin
            nerr++;
            $display("FAIL basic_frame: got valid=%0d gap=%0d ack=%0d, required 4 %0d 1", v, g, a, GAP);
        end
    endtask

    task automatic test_single_beat();
        int v, g, a;
        push_frame(1);
        request(1);
        drain(-1, 0, 1'b0, v, g, a);
        nchecks++;
        if (v != 1 || v + g != 1 + GAP || a != 1) begin
            nerr++;
            $display("FAIL single_beat: got valid=%0d busy=%0d ack=%0d, required 1 %0d 1", v, v + g, a, 1 + GAP);
        end
    endtask

    task automatic test_stall();
        int v, g, a;
        push_frame(5);
        request(5);
        drain(2, 3, 1'b0, v, g, a);
        nchecks++;
        if (v != 8 || g != GAP || a != 1) begin
            nerr++;
            $display("FAIL stall: got valid=%0d gap=%0d ack=%0d, required 8 %0d 1", v, g, a, GAP);
        end
    endtask

    task automatic test_zero_len_and_gap_req();
        int v, g, a;
        @(negedge clock_i);
        req_i     = 1'b1;
        req_len_i = '0;
        @(negedge clock_i);
        req_i = 1'b0;
        nchecks++;
        if (err_o !== 1'b1 || ack_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL zero_len: got err=%b ack=%b valid=%b busy=%b, required 1 0 0 0",
                     err_o, ack_o, valid_o, busy_o);
        end
        @(negedge clock_i);
        nchecks++;
        if (err_o !== 1'b0 || valid_o !== 1'b0) begin
            nerr++;
            $display("FAIL err_pulse: got err=%b valid=%b, required 0 0", err_o, valid_o);
        end
        push_frame(2);
        request(2);
        drain(-1, 0, 1'b1, v, g, a);
        @(negedge clock_i);
        nchecks++;
        if (v != 2 || g != GAP || a != 1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL gap_ignore: got valid=%0d gap=%0d ack=%0d err=%b busy=%b, required 2 %0d 1 0 0",
                     v, g, a, err_o, busy_o, GAP);
        end
    endtask

    task automatic test_back_to_back();
        int v, g, a;
        push_frame(2);
        @(negedge clock_i);
        req_i     = 1'b1;
        req_len_i = LEN_W'(2);
        @(negedge clock_i);
        drain(-1, 0, 1'b0, v, g, a);
        nchecks++;
        if (v != 2 || a != 1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_first: got valid=%0d ack=%0d busy=%b, required 2 1 0", v, a, busy_o);
        end
        push_frame(2);
        @(negedge clock_i);
        req_i = 1'b0;
        drain(-1, 0, 1'b0, v, g, a);
        nchecks++;
        if (v != 2 || a != 1) begin
            nerr++;
            $display("FAIL b2b_second: got valid=%0d ack=%0d, required 2 1", v, a);
        end
    endtask

    task automatic test_max_len();
        int v, g, a;
        push_frame(255);
        request(255);
        drain(-1, 0, 1'b0, v, g, a);
        nchecks++;
        if (v != 255 || a != 1) begin
            nerr++;
            $display("FAIL max_len: got valid=%0d ack=%0d, required 255 1", v, a);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v, g, a;
        int tails;
        request(6);
        @(negedge clock_i);
        nchecks++;
        if (valid_o !== 1'b1 || beat_cnt_o !== LEN_W'(1)) begin
            nerr++;
            $display("FAIL pre_reset_beat: got valid=%b cnt=%0d, required 1 1", valid_o, beat_cnt_o);
        end
        #1 reset_ni = 1'b0;
        #1;
        nchecks++;
        if ({ack_o, err_o, busy_o, head_o, tail_o, valid_o} !== 6'b0 || beat_cnt_o !== '0) begin
            nerr++;
            $display("FAIL async_reset: got ack/err/busy/head/tail/valid=%b cnt=%0d, required all 0",
                     {ack_o, err_o, busy_o, head_o, tail_o, valid_o}, beat_cnt_o);
        end
        @(negedge clock_i);
        reset_ni = 1'b1;
        tails = 0;
        repeat (8) begin
            @(negedge clock_i);
            if (tail_o || valid_o) tails++;
        end
        nchecks++;
        if (tails != 0 || busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL no_resume: got %0d beat cycles busy=%b, required 0 0", tails, busy_o);
        end
        push_frame(2);
        request(2);
        drain(-1, 0, 1'b0, v, g, a);
        nchecks++;
        if (v != 2 || g != GAP || a != 1) begin
            nerr++;
            $display("FAIL post_reset_frame: got valid=%0d gap=%0d ack=%0d, required 2 %0d 1", v, g, a, GAP);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_beat();
        test_stall();
        test_zero_len_and_gap_req();
        test_back_to_back();
        test_max_len();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
